// File: rtl/and3_resp_checker.sv
// Purpose : checks a 3-input AND DUT by comparing r against x&y&z of the stimulus
//           delayed by LATENCY, with sample/mismatch counters and input coverage.
// Latency : compares LATENCY cycles after a valid sample; every output is registered
//           (1 cycle after the compare edge).
// Backpressure: none; one sample per cycle is accepted in RUN, and samples are
//           dropped outside RUN.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle pulse, clears all results and (re)enters RUN
//   smp_vld,x,y,z : stimulus vector {x,y,z} valid this cycle
//   r             : DUT output, aligned LATENCY cycles after its stimulus
//   busy/done/pass: RUN / verdict reached / verdict is PASS
//   err           : sticky mismatch flag since the last start
//   smp_cnt       : number of compared samples (saturating)
//   err_cnt       : number of mismatches (saturating)
//   cov           : bit {x,y,z} is set once that combination has been compared
//   ff_vec, ff_idx: vector and sample index of the first mismatch
//                   (present only when FIRST_FAIL_CAPTURE_EN is defined)
module and3_resp_checker #(
  parameter int LATENCY = 0,     // legal range 0..4
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024   // must be < 2**CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smp_vld,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic             r,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       cov
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic [2:0]       ff_vec,
  output logic [CNT_W-1:0] ff_idx
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] smp_d, errc_d;
  logic [7:0]       cov_d;
  logic             err_d;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic [2:0]       ff_vec_d;
  logic [CNT_W-1:0] ff_idx_d;
`endif

  // A start cycle is a clearing cycle: nothing sampled or compared in it counts.
  logic       in_run;
  logic [3:0] pipe_in;   // {vld, x, y, z}
  logic [3:0] cmp_vec;   // vector whose response r carries this cycle
  logic       cmp_fire;
  logic       mism;

  assign in_run  = (state_q == S_RUN) && !start;
  assign pipe_in = {smp_vld & in_run, x, y, z};

  generate
    if (LATENCY == 0) begin : g_nopipe
      assign cmp_vec = pipe_in;
    end else begin : g_pipe
      logic [3:0] pipe_q [LATENCY];
      // Flushed whenever RUN is (re)entered or left, so stale vectors never
      // get compared against a later run's responses.
      always_ff @(posedge clk) begin
        if (rst || state_d != S_RUN || start) begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= pipe_in;
          for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign cmp_vec = pipe_q[LATENCY-1];
    end
  endgenerate

  assign cmp_fire = cmp_vec[3] & in_run;
  assign mism     = cmp_fire & (r != &cmp_vec[2:0]);

  always_comb begin
    state_d  = state_q;
    smp_d    = smp_cnt;
    errc_d   = err_cnt;
    cov_d    = cov;
    err_d    = err;
`ifdef FIRST_FAIL_CAPTURE_EN
    ff_vec_d = ff_vec;
    ff_idx_d = ff_idx;
`endif
    if (start) begin
      state_d  = S_RUN;
      smp_d    = '0;
      errc_d   = '0;
      cov_d    = '0;
      err_d    = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_vec_d = '0;
      ff_idx_d = '0;
`endif
    end else if (cmp_fire) begin
      if (smp_cnt != '1) smp_d = smp_cnt + CNT_W'(1);
      cov_d[cmp_vec[2:0]] = 1'b1;
      if (mism) begin
        if (err_cnt != '1) errc_d = err_cnt + CNT_W'(1);
        err_d = 1'b1;
`ifdef FIRST_FAIL_CAPTURE_EN
        if (!err) begin
          ff_vec_d = cmp_vec[2:0];
          ff_idx_d = smp_cnt;
        end
`endif
      end
      // Verdict uses the post-update values; full coverage beats timeout.
      if (&cov_d) begin
        state_d = (errc_d == '0) ? S_PASS : S_FAIL;
      end else if (smp_d == TIMEOUT_C) begin
        state_d = S_FAIL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err     <= 1'b0;
      smp_cnt <= '0;
      err_cnt <= '0;
      cov     <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_vec  <= '0;
      ff_idx  <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= (state_d == S_RUN);
      done    <= (state_d == S_PASS) || (state_d == S_FAIL);
      pass    <= (state_d == S_PASS);
      err     <= err_d;
      smp_cnt <= smp_d;
      err_cnt <= errc_d;
      cov     <= cov_d;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_vec  <= ff_vec_d;
      ff_idx  <= ff_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_and3_resp_checker.sv
// Purpose : directed checks of and3_resp_checker in three configurations driven
//           by shared stimulus: u0 (LATENCY=0, TIMEOUT=16), u2 (LATENCY=2,
//           TIMEOUT=16) and us (LATENCY=0, CNT_W=2, TIMEOUT=3).
// Each instance has its own response input r0/r2/rs.
module tb_and3_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, smp_vld, x, y, z, r0, r2, rs;

  logic        busy0, done0, pass0, err0;
  logic [15:0] smp0, errc0;
  logic [7:0]  cov0;
  logic        busy2, done2, pass2, err2;
  logic [15:0] smp2, errc2;
  logic [7:0]  cov2;
  logic        busys, dones, passs, errs;
  logic [1:0]  smps, errcs;
  logic [7:0]  covs;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic [2:0]  ffv0, ffv2, ffvs;
  logic [15:0] ffi0, ffi2;
  logic [1:0]  ffis;
`endif

  and3_resp_checker #(.LATENCY(0), .CNT_W(16), .TIMEOUT(16)) u0 (
    .clk(clk), .rst(rst), .start(start), .smp_vld(smp_vld), .x(x), .y(y), .z(z), .r(r0),
    .busy(busy0), .done(done0), .pass(pass0), .err(err0),
    .smp_cnt(smp0), .err_cnt(errc0), .cov(cov0)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .ff_vec(ffv0), .ff_idx(ffi0)
`endif
  );

  and3_resp_checker #(.LATENCY(2), .CNT_W(16), .TIMEOUT(16)) u2 (
    .clk(clk), .rst(rst), .start(start), .smp_vld(smp_vld), .x(x), .y(y), .z(z), .r(r2),
    .busy(busy2), .done(done2), .pass(pass2), .err(err2),
    .smp_cnt(smp2), .err_cnt(errc2), .cov(cov2)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .ff_vec(ffv2), .ff_idx(ffi2)
`endif
  );

  and3_resp_checker #(.LATENCY(0), .CNT_W(2), .TIMEOUT(3)) us (
    .clk(clk), .rst(rst), .start(start), .smp_vld(smp_vld), .x(x), .y(y), .z(z), .r(rs),
    .busy(busys), .done(dones), .pass(passs), .err(errs),
    .smp_cnt(smps), .err_cnt(errcs), .cov(covs)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .ff_vec(ffvs), .ff_idx(ffis)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; smp_vld = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Full 000..111 sweep followed by two idle cycles (to drain u2's pipe).
  // dly=1: r2 follows the stimulus two cycles late; dly=0: r2 is undelayed.
  // force_v: vector at which r0 is forced to 1 (-1 for none).
  task automatic sweep(input bit dly, input int force_v);
    logic [2:0] vs [10];
    logic [2:0] v;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      v = (i < 8) ? 3'(i) : 3'd0;
      vs[i] = v;
      smp_vld = (i < 8);
      {x, y, z} = v;
      r0 = (&v) | (int'(v) == force_v);
      r2 = dly ? ((i >= 2) ? &vs[i-2] : 1'b0) : &v;
      rs = &v;
      tick();
      if (i == 6) chk("u0_busy_before_8th", 32'(busy0), 1);
    end
    smp_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; smp_vld = 1'b0;
    x = 1'b0; y = 1'b0; z = 1'b0; r0 = 1'b0; r2 = 1'b0; rs = 1'b0;
    tick(); tick();
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_pass0", 32'(pass0), 0);
    chk("rst_err0",  32'(err0),  0);
    chk("rst_smp0",  32'(smp0),  0);
    chk("rst_cov0",  32'(cov0),  0);
    chk("rst_busy2", 32'(busy2), 0);
    chk("rst_errcs", 32'(errcs), 0);
    rst = 1'b0;

    // Samples in IDLE are ignored.
    smp_vld = 1'b1; {x, y, z} = 3'b111; r0 = 1'b0;
    tick(); tick();
    smp_vld = 1'b0;
    chk("idle_smp0",  32'(smp0),  0);
    chk("idle_err0",  32'(err0),  0);
    chk("idle_busy0", 32'(busy0), 0);

    // Correct sweep: u0 passes after 8 compares, u2 passes with delayed r.
    sweep(1'b1, -1);
    chk("s1_u0_pass", 32'(pass0), 1);
    chk("s1_u0_done", 32'(done0), 1);
    chk("s1_u0_busy", 32'(busy0), 0);
    chk("s1_u0_smp",  32'(smp0),  8);
    chk("s1_u0_errc", 32'(errc0), 0);
    chk("s1_u0_cov",  32'(cov0),  32'hFF);
    chk("s1_u2_pass", 32'(pass2), 1);
    chk("s1_u2_smp",  32'(smp2),  8);
    chk("s1_u2_err",  32'(err2),  0);
    chk("s1_us_fail", 32'({dones, passs}), 32'b10);
    chk("s1_us_smp",  32'(smps),  3);
    chk("s1_us_cov",  32'(covs),  32'h07);

    // Restart from PASS/FAIL: r0 wrong at 110; r2 undelayed so u2 mismatches
    // at vectors 101 and 111.
    sweep(1'b0, 6);
    chk("s2_u0_done", 32'(done0), 1);
    chk("s2_u0_pass", 32'(pass0), 0);
    chk("s2_u0_errc", 32'(errc0), 1);
    chk("s2_u0_err",  32'(err0),  1);
    chk("s2_u0_smp",  32'(smp0),  8);
    chk("s2_u2_done", 32'(done2), 1);
    chk("s2_u2_pass", 32'(pass2), 0);
    chk("s2_u2_err",  32'(err2),  1);
    chk("s2_u2_errc", 32'(errc2), 2);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("s2_u0_ffvec", 32'(ffv0), 6);
    chk("s2_u0_ffidx", 32'(ffi0), 6);
`endif

    // Timeout: 16 correct samples of only 000/001.
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      smp_vld = 1'b1; {x, y, z} = (i % 2 == 1) ? 3'b001 : 3'b000;
      r0 = 1'b0; r2 = 1'b0; rs = 1'b0;
      tick();
      if (i == 14) chk("to_busy_at_15", 32'(busy0), 1);
    end
    smp_vld = 1'b0;
    chk("to_done", 32'(done0), 1);
    chk("to_pass", 32'(pass0), 0);
    chk("to_smp",  32'(smp0),  16);
    chk("to_cov",  32'(cov0),  32'h03);
    chk("to_errc", 32'(errc0), 0);
    chk("to_us_cov", 32'(covs), 32'h03);

    // Saturation: five mismatching 111 samples on the 2-bit instance.
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      smp_vld = 1'b1; {x, y, z} = 3'b111; r0 = 1'b0; rs = 1'b0;
      tick();
      if (i == 1) begin
        chk("sat_errc_2", 32'(errcs), 2);
        chk("sat_busy_2", 32'(busys), 1);
      end
      if (i == 2) begin
        chk("sat_fail_3", 32'({dones, passs}), 32'b10);
        chk("sat_errc_3", 32'(errcs), 3);
        chk("sat_smp_3",  32'(smps),  3);
      end
    end
    smp_vld = 1'b0;
    chk("sat_errc_hold", 32'(errcs), 3);
    chk("sat_err",       32'(errs),  1);
    chk("sat_u0_errc",   32'(errc0), 5);

    // Mid-RUN restart, then reset.
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      smp_vld = 1'b1; {x, y, z} = 3'(i); r0 = (i == 1);
      tick();
    end
    chk("mid_smp_pre", 32'(smp0), 3);
    chk("mid_err_pre", 32'(err0), 1);
    chk("mid_cov_pre", 32'(cov0), 32'h07);
    start = 1'b1; smp_vld = 1'b1; {x, y, z} = 3'b011; r0 = 1'b1;
    tick();
    start = 1'b0; smp_vld = 1'b0;
    chk("mid_smp",  32'(smp0),  0);
    chk("mid_errc", 32'(errc0), 0);
    chk("mid_cov",  32'(cov0),  0);
    chk("mid_err",  32'(err0),  0);
    chk("mid_busy", 32'(busy0), 1);
    chk("mid_done", 32'(done0), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("mid_ffvec", 32'(ffv0), 0);
`endif
    smp_vld = 1'b1; {x, y, z} = 3'b101; r0 = 1'b0;
    tick();
    smp_vld = 1'b0;
    chk("mid_smp_after", 32'(smp0), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_busy0", 32'(busy0), 0);
    chk("rr_done0", 32'(done0), 0);
    chk("rr_pass0", 32'(pass0), 0);
    chk("rr_smp0",  32'(smp0),  0);
    chk("rr_cov0",  32'(cov0),  0);
    chk("rr_busy2", 32'(busy2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/and3_resp_checker.md
Name: and3_resp_checker

Overview:
Synthesizable response checker on the receiving end of 3-input AND gate stimulus. It samples the stimulus vector (x,y,z) and the device-under-test output r, then compares r against the golden value x&y&z. The DUT's output latency is configurable. The block counts samples and mismatches, tracks coverage of all 8 input combinations, and reports a final PASS/FAIL verdict. It sits beside the and_gate under test in self-checking benches and on-board test fixtures.

Parameters:
LATENCY, 0, clock cycles between a valid stimulus sample and the matching r; legal range 0..4
CNT_W, 16, width of the sample and mismatch counters
TIMEOUT, 1024, compared samples allowed in RUN before FAIL if coverage is incomplete; must be < 2^CNT_W

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: clear and begin checking
smp_vld  in  1  x,y,z valid this cycle
x  in  1  stimulus bit 2
y  in  1  stimulus bit 1
z  in  1  stimulus bit 0
r  in  1  DUT output
busy  out  1  high in RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS only
err  out  1  sticky, set on first mismatch since start
smp_cnt  out  CNT_W  compared samples, saturating
err_cnt  out  CNT_W  mismatches, saturating
cov  out  8  bit {x,y,z} set once that combination has been compared

Behaviour:
- One clock; reset is synchronous and active-high: rst sampled on rising clk edge, no asynchronous path.
- Reset values: state IDLE; busy=0, done=0, pass=0, err=0; smp_cnt=0, err_cnt=0, cov=8'h00; delay pipe valid bits cleared.
- All outputs are registered.
- States: IDLE, RUN, PASS, FAIL.
  - IDLE -start-> RUN.
  - RUN -cov full & err_cnt==0-> PASS.
  - RUN -cov full & err_cnt!=0-> FAIL.
  - RUN -smp_cnt==TIMEOUT & cov not full-> FAIL.
  - PASS/FAIL -start-> RUN.
- start in any state, including RUN: clears counters, cov, err, and the pipe; enters RUN next edge. Samples presented in the start cycle are ignored.
- Delay pipe: in RUN, each smp_vld pushes {vld, x, y, z} into a LATENCY-deep shift register that advances every cycle.
  - LATENCY=0: compare the same cycle, no pipe.
  - Compare when the pipe output valid=1: exp = x&y&z of the stored vector; mismatch = (r != exp).
- Per compare edge: smp_cnt+1; cov[{x,y,z}] <= 1; on mismatch err_cnt+1 and err <= 1. Counters saturate at all-ones, no wrap.
- Verdict is evaluated on the same edge using post-update values. A sample that completes coverage and mismatches yields FAIL, not PASS.
- Leaving RUN: pipe contents discarded, further samples ignored, counters frozen until the next start.
- Timeout and coverage completing on the same edge: coverage takes precedence (verdict by err_cnt).
- rst mid-RUN: immediate return to reset values on that edge.

Optional Feature:
FIRST_FAIL_CAPTURE_EN.
- Defined: adds outputs ff_vec (3b, {x,y,z} of the first mismatch) and ff_idx (CNT_W, smp_cnt value before increment on that mismatch). Both are 0 on rst/start and hold after capture until the next start.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- LATENCY=0; start, then 8 valid samples 000..111 with r=x&y&z each cycle -> cov=8'hFF, smp_cnt=8, err_cnt=0, PASS on the 8th compare edge, pass=1, done=1.
- LATENCY=2; same sweep with r delayed 2 cycles -> PASS, smp_cnt=8. The same r undelayed -> err=1, FAIL.
- LATENCY=0; sweep with r forced 1 at vector 110 -> err_cnt=1, FAIL; with FIRST_FAIL_CAPTURE_EN, ff_vec=3'b110, ff_idx=6.
- TIMEOUT=16; 16 samples of only 000 and 001, all correct -> FAIL at smp_cnt=16, cov=8'h03, err_cnt=0.
- Mid-RUN start after 3 samples -> counters and cov return to 0 next edge, state RUN. Then assert rst -> all outputs at reset values, state IDLE.
- CNT_W=2, TIMEOUT=3; 5 mismatching samples of 111 -> err_cnt holds 3 (saturated), FAIL at the 3rd compare.
